// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin arbiter with bounded hold in front of BUS
module bus_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_wr,
  input  logic        m1_wr,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m1_addr,
  input  logic [63:0] m0_dout,
  input  logic [63:0] m1_dout,
  output logic        m0_grant,
  output logic        m1_grant,
  output logic [63:0] m0_din,
  output logic [63:0] m1_din,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [15:0] bus_addr,
  output logic [63:0] bus_dout,
  input  logic        bus_grant,
  input  logic [63:0] bus_din
);

  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_M0   = 2'd1;
  localparam logic [1:0] OWN_M1   = 2'd2;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [1:0]      din_owner_q, din_owner_d;
  logic            other_req;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req && m1_req) state_d = last_q ? GNT0 : GNT1;
        else if (m0_req)      state_d = GNT0;
        else if (m1_req)      state_d = GNT1;
      end
      GNT0: begin
        if (!m0_req)                                 state_d = m1_req ? GNT1 : IDLE;
        else if (m1_req && hold_cnt_q == HOLD_LAST)  state_d = GNT1;
      end
      GNT1: begin
        if (!m1_req)                                 state_d = m0_req ? GNT0 : IDLE;
        else if (m0_req && hold_cnt_q == HOLD_LAST)  state_d = GNT0;
      end
      default: state_d = IDLE;
    endcase
  end

  // hold_cnt only advances while the non-owner is waiting, so a lone master never times out
  always_comb begin
    other_req = (state_q == GNT0) ? m1_req : (state_q == GNT1) ? m0_req : 1'b0;

    last_d = last_q;
    if (state_d != state_q && state_d == GNT0) last_d = 1'b0;
    if (state_d != state_q && state_d == GNT1) last_d = 1'b1;

    hold_cnt_d = hold_cnt_q;
    if (state_d != state_q)                       hold_cnt_d = '0;
    else if (other_req && hold_cnt_q != HOLD_LAST) hold_cnt_d = hold_cnt_q + HW'(1);

    din_owner_d = m0_grant ? OWN_M0 : (m1_grant ? OWN_M1 : OWN_NONE);
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      hold_cnt_q  <= '0;
      din_owner_q <= OWN_NONE;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      hold_cnt_q  <= hold_cnt_d;
      din_owner_q <= din_owner_d;
    end
  end

  assign m0_grant = (state_q == GNT0) && bus_grant;
  assign m1_grant = (state_q == GNT1) && bus_grant;
  assign bus_req  = (state_q != IDLE);

  assign bus_wr   = (state_q == GNT0) ? m0_wr   : (state_q == GNT1) ? m1_wr   : 1'b0;
  assign bus_addr = (state_q == GNT0) ? m0_addr : (state_q == GNT1) ? m1_addr : 16'h0;
  assign bus_dout = (state_q == GNT0) ? m0_dout : (state_q == GNT1) ? m1_dout : 64'h0;

  // read data follows the registered owner, matching BUS's one-cycle select delay
  assign m0_din = (din_owner_q == OWN_M0) ? bus_din : 64'h0;
  assign m1_din = (din_owner_q == OWN_M1) ? bus_din : 64'h0;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter in front of the single-master `BUS` block. It accepts requests from master 0 and master 1 and selects one owner with round-robin fairness and a bounded hold time. It muxes the owner's write/address/data onto the `BUS` master port and returns `BUS` read data only to the master that issued the access. It sits between the factorial-calculator masters and `BUS`, and drives `BUS` `m_req`/`m_wr`/`m_addr`/`m_dout`.

## Interface
Parameters:
- `MAX_HOLD`, default 16: maximum consecutive owner cycles while the other master is requesting; legal range ≥ 2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-high reset (asserted = 1).
- `m0_req`, `m1_req`  in  1  bus request from master 0 / 1; held high for the whole transfer sequence.
- `m0_wr`, `m1_wr`  in  1  write strobe from master 0 / 1.
- `m0_addr`, `m1_addr`  in  16  address from master 0 / 1.
- `m0_dout`, `m1_dout`  in  64  write data from master 0 / 1.
- `m0_grant`, `m1_grant`  out  1  master owns `BUS` this cycle.
- `m0_din`, `m1_din`  out  64  read data to master 0 / 1.
- `bus_req`  out  1  to `BUS` `m_req`.
- `bus_wr`  out  1  to `BUS` `m_wr`.
- `bus_addr`  out  16  to `BUS` `m_addr`.
- `bus_dout`  out  64  to `BUS` `m_dout`.
- `bus_grant`  in  1  from `BUS` `m_grant`; registered copy of `bus_req`.
- `bus_din`  in  64  from `BUS` `m_din`.

## Operation
- FSM states: IDLE, GNT0, GNT1. State, `last` (last served master, 1 bit), `hold_cnt`, and `din_owner` (2 bits: none/0/1) are all registers.
- IDLE:
  - Only `m0_req` high → GNT0. Only `m1_req` high → GNT1.
  - Both high → grant the master other than `last`.
  - Neither → stay in IDLE.
- GNTx, evaluated in priority order:
  - `mx_req` low: go to GNTy if `my_req` is high, else IDLE.
  - `my_req` high and `hold_cnt == MAX_HOLD-1`: preempt to GNTy.
  - Otherwise stay in GNTx.
- `last` updates to x on every entry into GNTx.
- `hold_cnt` clears on every state change. It increments each cycle spent in GNTx while `my_req` is high, and saturates at `MAX_HOLD-1`. It stays at 0 while the other master is idle, so a lone master may hold indefinitely.
- `bus_req` = (state != IDLE).
- `bus_wr`/`bus_addr`/`bus_dout` pass through from the owner. They are forced to 0 in IDLE.
- `mx_grant` = (state == GNTx) & `bus_grant`.
  - A master must not drive an access without `mx_grant` high.
  - Accesses issued without a grant are ignored, because `BUS` zeroes them.
- Read data ownership:
  - `din_owner` ← owner if that owner's grant is high, else none. This is the registered state, matching the one-cycle `s_sel` delay inside `BUS`.
  - `mx_din` = `bus_din` when `din_owner` == x, else 64'h0.
- Preemption gives no warning. A master that loses its grant mid-sequence must keep `req` high and wait for its grant to return.

## Timing
- Reset values:
  - state = IDLE, `last` = 1 (master 0 wins the first tie), `hold_cnt` = 0, `din_owner` = none.
  - All outputs 0: `m0_grant`, `m1_grant`, `bus_req`, `bus_wr`, `bus_addr`, `bus_dout`, `m0_din`, `m1_din`.
- Reset asserted mid-transfer: everything returns to IDLE immediately (asynchronously).
- Grant latency from IDLE:
  - Request sampled high at edge t → state = GNTx and `bus_req` = 1 after edge t.
  - `bus_grant` = 1 after edge t+1, so `mx_grant` first goes high in cycle t+2. Worst case is 2 cycles.
- Handover GNTx→GNTy:
  - `bus_req` stays 1 and `bus_grant` stays 1.
  - `my_grant` rises in the cycle right after the state change, with no dead cycle.
  - `mx_grant` falls on the same edge.
- Release to IDLE: `mx_grant` falls after the edge where `mx_req` was sampled low.
- Read data returns one cycle after the granted read address. It is steered by `din_owner`, so the last read before a handover still reaches the previous owner.
- Simultaneous release of x and rise of y's request in the same cycle: direct handover to GNTy, no pass through IDLE.

## Test plan
- Single master: after reset, `m0_req`=1 at cycle 1 → `bus_req`=1 at cycle 2, `m0_grant`=1 at cycle 3; `m1_grant` stays 0; a read of addr 16'h0000 returns `bus_din` on `m0_din` one cycle later, with `m1_din` = 0.
- Tie and round-robin: both requests rise together after reset → GNT0 first; m0 drops its request after 3 cycles → `m1_grant` high the next cycle with `bus_req` continuously 1; both re-request from IDLE → GNT1 is not chosen again, master 0 wins.
- Preemption with MAX_HOLD=4: m0 holds, m1 requests at cycle k → `m0_grant` falls and `m1_grant` rises exactly 4 cycles after k, while m0 still requests → m0 regains the bus after a further 4 cycles.
- Lone hold: m0 requests for 100 cycles with m1 idle → `m0_grant` is never dropped and `hold_cnt` stays 0.
- Read steering across handover: m0's last read is issued in the final GNT0 cycle → its data appears on `m0_din` (not `m1_din`) in the first GNT1 cycle.
- Reset mid-transfer: `reset_n`=1 asserted during GNT1 → all outputs 0 in the same cycle; after release, `last`=1 and a tie grants master 0.
